nettlp_cmd_regfile: RTL and testbench
=====================================

Name: nettlp_cmd_regfile

Overview:
- Parametrised adapter register file behind the NetTLP command channel.
- Pops register read/write commands from a first-word-fall-through input FIFO and executes them against NUM_REGS 32-bit registers.
- Pushes responses to an output FIFO; exports live register values and per-register write strobes to the rest of the adapter (packet builder: MAC/IP/port fields).
- Successor to the fixed 9-register command core. Adds: configurable depth, read-only mask, optional byte swap, write acknowledgements, error responses, status counters.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..2**ADDR_W).
- ADDR_W, 8, dwaddr field width.
- OPC_W, 4, opcode field width.
- OPC_RD, 4'h1, register-read opcode.
- OPC_WR, 4'h2, register-write opcode.
- OPC_ERR, 4'hF, opcode placed in error responses.
- RO_MASK, '0 (NUM_REGS bits), bit i=1 makes register i read-only.
- RST_VALUES, '0 (NUM_REGS*32 bits), reset value of register i at bits [32i+31:32i].
- BYTE_SWAP, 1, 1 = command data is network byte order and is byte-reversed on read and write; 0 = passed unchanged.
- WR_ACK, 1, 1 = successful writes produce a response; 0 = writes are silent.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fifo_cmd_i_rd_en  out  1  pop pulse.
- fifo_cmd_i_empty  in  1  input FIFO empty.
- fifo_cmd_i_dout  in  OPC_W+ADDR_W+32  command word {opcode, dwaddr, data}.
- fifo_cmd_o_wr_en  out  1  push pulse.
- fifo_cmd_o_full  in  1  output FIFO full.
- fifo_cmd_o_din  out  OPC_W+ADDR_W+32  response word {opcode, dwaddr, data}.
- reg_q  out  NUM_REGS*32  current register values, native (unswapped) order.
- reg_wr_stb  out  NUM_REGS  one-cycle pulse on bit i when register i is updated.
- cmd_cnt  out  32  accepted commands, wraps.
- err_cnt  out  16  error events, saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous assert): state IDLE; fifo_cmd_i_rd_en, fifo_cmd_o_wr_en, reg_wr_stb = 0; fifo_cmd_o_din = 0; reg_q = RST_VALUES; counters = 0.
- Reset mid-operation: any latched command is discarded with no response. Reset deassertion is used synchronously.
- FSM states: IDLE, EXEC, SEND.
- IDLE: if !empty, pulse fifo_cmd_i_rd_en for exactly one cycle, latch dout, increment cmd_cnt, go to EXEC. rd_en is never high in any other state.
- EXEC, OPC_RD, addr < NUM_REGS: response = {OPC_RD, addr, swap(reg[addr])}, go to SEND.
- EXEC, OPC_RD, addr >= NUM_REGS: response = {OPC_ERR, addr, 32'hFFFF_FFFF}, err_cnt++, go to SEND.
- EXEC, OPC_WR, addr < NUM_REGS, RO_MASK[addr]=0: reg[addr] <= swap(data), pulse reg_wr_stb[addr].
  - WR_ACK=1: response = {OPC_WR, addr, data}, go to SEND.
  - WR_ACK=0: go to IDLE.
- EXEC, OPC_WR, read-only or out-of-range address: no register change, no strobe, err_cnt++.
  - WR_ACK=1: response = {OPC_ERR, addr, data}, go to SEND.
  - WR_ACK=0: go to IDLE.
- EXEC, any other opcode: err_cnt++, no response, go to IDLE.
- swap(x) = {x[7:0], x[15:8], x[23:16], x[31:24]} when BYTE_SWAP=1; identity otherwise.
- SEND: hold fifo_cmd_o_din stable.
  - On the first cycle with !fifo_cmd_o_full: fifo_cmd_o_wr_en = 1 for exactly one cycle, go to IDLE.
  - While full: wait indefinitely, wr_en stays 0.
- Timing: rd_en at cycle N; EXEC at N+1; earliest wr_en at N+2. Earliest next rd_en is N+3 after SEND, or N+2 for silent or dropped commands.
- reg_q updates the cycle after EXEC. A read that immediately follows a write to the same address returns the new value.
- err_cnt does not wrap: held at FFFF. cmd_cnt wraps FFFF_FFFF -> 0.
- Registered outputs only; no combinational path from input ports to output ports.

Test Plan:
- Reset with NUM_REGS=9, RST_VALUES[0]=32'h01234567, BYTE_SWAP=1; read addr 0 -> response {OPC_RD, 0, 32'h67452301}; cmd_cnt=1, err_cnt=0.
- Write addr 5 data 32'hC0A80A03 -> reg_q[5] = 32'h030AA8C0; reg_wr_stb[5] pulses one cycle; ack {OPC_WR, 5, C0A80A03}; read addr 5 back returns C0A80A03.
- RO_MASK[0]=1, write addr 0 data 32'hDEADBEEF -> reg 0 unchanged, no strobe, response {OPC_ERR, 0, DEADBEEF}, err_cnt=1. Read addr 12 -> {OPC_ERR, 12, FFFFFFFF}, err_cnt=2.
- Output full held 20 cycles during a read -> no wr_en and din stable throughout; full drops -> single wr_en pulse; rd_en stays low until then.
- Opcode 4'h7 followed by a valid read, back-to-back in the FIFO -> one response only (the read); err_cnt=1; cmd_cnt=2.
- Assert rst while in SEND with full=1 -> outputs 0 immediately, registers return to RST_VALUES, no response emitted after release.

Source files
------------

// File: rtl/nettlp_cmd_regfile.sv
// NetTLP command-channel register file: pops {opcode, dwaddr, data} commands,
// executes reads/writes against NUM_REGS 32-bit registers and pushes responses.
module nettlp_cmd_regfile #(
   parameter int                     NUM_REGS   = 16,
   parameter int                     ADDR_W     = 8,
   parameter int                     OPC_W      = 4,
   parameter logic [OPC_W-1:0]       OPC_RD     = 4'h1,
   parameter logic [OPC_W-1:0]       OPC_WR     = 4'h2,
   parameter logic [OPC_W-1:0]       OPC_ERR    = 4'hF,
   parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
   parameter logic [NUM_REGS*32-1:0] RST_VALUES = '0,
   parameter bit                     BYTE_SWAP  = 1'b1,
   parameter bit                     WR_ACK     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        fifo_cmd_i_rd_en,
   input  logic                        fifo_cmd_i_empty,
   input  logic [OPC_W+ADDR_W+32-1:0]  fifo_cmd_i_dout,
   output logic                        fifo_cmd_o_wr_en,
   input  logic                        fifo_cmd_o_full,
   output logic [OPC_W+ADDR_W+32-1:0]  fifo_cmd_o_din,
   output logic [NUM_REGS*32-1:0]      reg_q,
   output logic [NUM_REGS-1:0]         reg_wr_stb,
   output logic [31:0]                 cmd_cnt,
   output logic [15:0]                 err_cnt
);

   localparam int CMD_W = OPC_W + ADDR_W + 32;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SEND} state_t;

   state_t              state_q;
   logic [OPC_W-1:0]    opc_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         data_q;
   logic [31:0]         regs_q [NUM_REGS];
   logic                rd_en_q;
   logic                wr_en_q;
   logic [CMD_W-1:0]    din_q;
   logic [NUM_REGS-1:0] stb_q;
   logic [31:0]         cmd_cnt_q;
   logic [15:0]         err_cnt_q;

   logic                in_range;
   logic                wr_ok;
   logic [IDX_W-1:0]    idx;
   logic [15:0]         err_cnt_d;

   function automatic logic [31:0] swap(input logic [31:0] x);
      return BYTE_SWAP ? {x[7:0], x[15:8], x[23:16], x[31:24]} : x;
   endfunction

   assign idx       = addr_q[IDX_W-1:0];
   assign in_range  = ({1'b0, addr_q} < NUM_REGS_W);
   assign wr_ok     = in_range && !RO_MASK[idx];
   // Error counter sticks at all-ones instead of wrapping.
   assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         opc_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         din_q     <= '0;
         stb_q     <= '0;
         cmd_cnt_q <= '0;
         err_cnt_q <= '0;
         // NOTE: the register array is reset on purpose; it holds live packet-builder fields.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RST_VALUES[i*32 +: 32];
         end
      end else begin
         // NOTE: non-blocking everywhere so every branch sees the pre-edge state.
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         stb_q   <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (!fifo_cmd_i_empty) begin
                  rd_en_q                  <= 1'b1;
                  {opc_q, addr_q, data_q}  <= fifo_cmd_i_dout;
                  cmd_cnt_q                <= cmd_cnt_q + 32'd1;
                  state_q                  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_q <= ST_IDLE;
               if (opc_q == OPC_RD) begin
                  state_q <= ST_SEND;
                  if (in_range) begin
                     din_q <= {OPC_RD, addr_q, swap(regs_q[idx])};
                  end else begin
                     din_q     <= {OPC_ERR, addr_q, 32'hFFFF_FFFF};
                     err_cnt_q <= err_cnt_d;
                  end
               end else if (opc_q == OPC_WR) begin
                  if (wr_ok) begin
                     regs_q[idx] <= swap(data_q);
                     stb_q[idx]  <= 1'b1;
                  end else begin
                     err_cnt_q <= err_cnt_d;
                  end
                  if (WR_ACK) begin
                     din_q   <= {(wr_ok ? OPC_WR : OPC_ERR), addr_q, data_q};
                     state_q <= ST_SEND;
                  end
               end else begin
                  err_cnt_q <= err_cnt_d;
               end
            end
            ST_SEND: begin
               if (!fifo_cmd_o_full) begin
                  wr_en_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign reg_q[g*32 +: 32] = regs_q[g];
   end

   assign fifo_cmd_i_rd_en = rd_en_q;
   assign fifo_cmd_o_wr_en = wr_en_q;
   assign fifo_cmd_o_din   = din_q;
   assign reg_wr_stb       = stb_q;
   assign cmd_cnt          = cmd_cnt_q;
   assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_nettlp_cmd_regfile.sv
// Directed bench for nettlp_cmd_regfile: bench-side FWFT command FIFO and
// response capture, one task per scenario with inline expected values.
module tb_nettlp_cmd_regfile;

   localparam int NR = 9;
   localparam int W  = 4 + 8 + 32;
   localparam logic [NR*32-1:0] RSTV = {256'h0, 32'h0123_4567};

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en;
   logic          empty;
   logic [W-1:0]  dout;
   logic          wr_en;
   logic          full;
   logic [W-1:0]  din;
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0] stb;
   logic [31:0]   cmd_cnt;
   logic [15:0]   err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int stb_cnt = 0;
   logic [NR-1:0] stb_last;
   logic [W-1:0] cmd_q[$];
   logic [W-1:0] rsp_q[$];
   int rd_times[$];
   int wr_times[$];

   always #5 clk = ~clk;

   nettlp_cmd_regfile #(
      .NUM_REGS(NR), .ADDR_W(8), .OPC_W(4),
      .OPC_RD(4'h1), .OPC_WR(4'h2), .OPC_ERR(4'hF),
      .RO_MASK(9'h001), .RST_VALUES(RSTV),
      .BYTE_SWAP(1'b1), .WR_ACK(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_cmd_i_rd_en(rd_en), .fifo_cmd_i_empty(empty), .fifo_cmd_i_dout(dout),
      .fifo_cmd_o_wr_en(wr_en), .fifo_cmd_o_full(full), .fifo_cmd_o_din(din),
      .reg_q(reg_q), .reg_wr_stb(stb), .cmd_cnt(cmd_cnt), .err_cnt(err_cnt)
   );

   function automatic logic [W-1:0] mk(input logic [3:0] o, input logic [7:0] a, input logic [31:0] d);
      return {o, a, d};
   endfunction

   function automatic logic [31:0] reg_at(input int i);
      return reg_q[i*32 +: 32];
   endfunction

   task automatic drive_fifo();
      empty = (cmd_q.size() == 0);
      dout  = (cmd_q.size() != 0) ? cmd_q[0] : '0;
   endtask

   // All bench activity happens on the falling edge, away from the DUT's sampling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rd_en) begin
         if (cmd_q.size() != 0) cmd_q.delete(0);
         rd_times.push_back(cyc);
      end
      if (wr_en) begin
         rsp_q.push_back(din);
         wr_times.push_back(cyc);
      end
      if (stb != '0) begin
         stb_cnt++;
         stb_last = stb;
      end
      drive_fifo();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic push_cmd(input logic [3:0] o, input logic [7:0] a, input logic [31:0] d);
      cmd_q.push_back(mk(o, a, d));
      drive_fifo();
   endtask

   task automatic clear_logs();
      rsp_q.delete();
      rd_times.delete();
      wr_times.delete();
      stb_cnt = 0;
   endtask

   task automatic wait_rsp(input int want, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && rsp_q.size() < want; i++) tick();
      ok = (rsp_q.size() >= want);
   endtask

   task automatic test_reset();
      rst = 1'b1; full = 1'b0; drive_fifo();
      run(3);
      total++; if (rd_en !== 1'b0)        begin bad++; $display("FAIL rst_rd_en got=%b want=0", rd_en); end
      total++; if (wr_en !== 1'b0)        begin bad++; $display("FAIL rst_wr_en got=%b want=0", wr_en); end
      total++; if (din !== '0)            begin bad++; $display("FAIL rst_din got=%h want=0", din); end
      total++; if (stb !== '0)            begin bad++; $display("FAIL rst_stb got=%h want=0", stb); end
      total++; if (cmd_cnt !== 32'd0)     begin bad++; $display("FAIL rst_cmd_cnt got=%0d want=0", cmd_cnt); end
      total++; if (err_cnt !== 16'd0)     begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
      total++; if (reg_at(0) !== 32'h0123_4567) begin bad++; $display("FAIL rst_reg0 got=%h want=01234567", reg_at(0)); end
      total++; if (reg_at(5) !== 32'h0)   begin bad++; $display("FAIL rst_reg5 got=%h want=0", reg_at(5)); end
      rst = 1'b0;
      run(3);
      total++; if (rd_times.size() != 0)  begin bad++; $display("FAIL idle_no_pop got=%0d want=0", rd_times.size()); end
   endtask

   task automatic test_read_reset();
      bit ok;
      clear_logs();
      push_cmd(4'h1, 8'd0, 32'h0);
      wait_rsp(1, 20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rd0_timeout got=%0d want=1", rsp_q.size()); end
      else if (rsp_q[0] !== mk(4'h1, 8'd0, 32'h6745_2301)) begin bad++; $display("FAIL rd0_rsp got=%h want=%h", rsp_q[0], mk(4'h1, 8'd0, 32'h6745_2301)); end
      run(2);
      total++; if (cmd_cnt !== 32'd1) begin bad++; $display("FAIL rd0_cmd_cnt got=%0d want=1", cmd_cnt); end
      total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL rd0_err_cnt got=%0d want=0", err_cnt); end
   endtask

   task automatic test_write();
      bit ok;
      clear_logs();
      push_cmd(4'h2, 8'd5, 32'hC0A8_0A03);
      wait_rsp(1, 20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wr5_timeout got=%0d want=1", rsp_q.size()); end
      else if (rsp_q[0] !== mk(4'h2, 8'd5, 32'hC0A8_0A03)) begin bad++; $display("FAIL wr5_ack got=%h want=%h", rsp_q[0], mk(4'h2, 8'd5, 32'hC0A8_0A03)); end
      total++; if (reg_at(5) !== 32'h030A_A8C0) begin bad++; $display("FAIL wr5_reg got=%h want=030aa8c0", reg_at(5)); end
      total++; if (stb_cnt != 1)          begin bad++; $display("FAIL wr5_stb_cycles got=%0d want=1", stb_cnt); end
      total++; if (stb_last !== 9'h020)   begin bad++; $display("FAIL wr5_stb_bits got=%h want=020", stb_last); end
      push_cmd(4'h1, 8'd5, 32'h0);
      wait_rsp(2, 20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rd5_timeout got=%0d want=2", rsp_q.size()); end
      else if (rsp_q[1] !== mk(4'h1, 8'd5, 32'hC0A8_0A03)) begin bad++; $display("FAIL rd5_rsp got=%h want=%h", rsp_q[1], mk(4'h1, 8'd5, 32'hC0A8_0A03)); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_logs();
      push_cmd(4'h2, 8'd3, 32'h1122_3344);
      push_cmd(4'h1, 8'd3, 32'h0);
      wait_rsp(2, 30, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d want=2", rsp_q.size()); end
      else begin
         total++; if (rsp_q[0] !== mk(4'h2, 8'd3, 32'h1122_3344)) begin bad++; $display("FAIL b2b_ack got=%h want=%h", rsp_q[0], mk(4'h2, 8'd3, 32'h1122_3344)); end
         total++; if (rsp_q[1] !== mk(4'h1, 8'd3, 32'h1122_3344)) begin bad++; $display("FAIL b2b_rd got=%h want=%h", rsp_q[1], mk(4'h1, 8'd3, 32'h1122_3344)); end
         total++; if (wr_times[0] - rd_times[0] != 2) begin bad++; $display("FAIL b2b_rd_to_wr got=%0d want=2", wr_times[0] - rd_times[0]); end
         total++; if (rd_times[1] - rd_times[0] != 3) begin bad++; $display("FAIL b2b_rd_to_rd got=%0d want=3", rd_times[1] - rd_times[0]); end
      end
      total++; if (reg_at(3) !== 32'h4433_2211) begin bad++; $display("FAIL b2b_reg3 got=%h want=44332211", reg_at(3)); end
      total++; if (cmd_cnt !== 32'd5) begin bad++; $display("FAIL b2b_cmd_cnt got=%0d want=5", cmd_cnt); end
   endtask

   task automatic test_errors();
      bit ok;
      clear_logs();
      push_cmd(4'h2, 8'd0, 32'hDEAD_BEEF);
      wait_rsp(1, 20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ro_timeout got=%0d want=1", rsp_q.size()); end
      else if (rsp_q[0] !== mk(4'hF, 8'd0, 32'hDEAD_BEEF)) begin bad++; $display("FAIL ro_rsp got=%h want=%h", rsp_q[0], mk(4'hF, 8'd0, 32'hDEAD_BEEF)); end
      total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL ro_err_cnt got=%0d want=1", err_cnt); end
      push_cmd(4'h1, 8'd12, 32'h0);
      push_cmd(4'h2, 8'd9, 32'hAABB_CCDD);
      wait_rsp(3, 30, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL oor_timeout got=%0d want=3", rsp_q.size()); end
      else begin
         total++; if (rsp_q[1] !== mk(4'hF, 8'd12, 32'hFFFF_FFFF)) begin bad++; $display("FAIL oor_rd got=%h want=%h", rsp_q[1], mk(4'hF, 8'd12, 32'hFFFF_FFFF)); end
         total++; if (rsp_q[2] !== mk(4'hF, 8'd9, 32'hAABB_CCDD)) begin bad++; $display("FAIL oor_wr got=%h want=%h", rsp_q[2], mk(4'hF, 8'd9, 32'hAABB_CCDD)); end
      end
      run(2);
      total++; if (reg_at(0) !== 32'h0123_4567) begin bad++; $display("FAIL ro_reg0 got=%h want=01234567", reg_at(0)); end
      total++; if (stb_cnt != 0)       begin bad++; $display("FAIL err_stb_cycles got=%0d want=0", stb_cnt); end
      total++; if (err_cnt !== 16'd3)  begin bad++; $display("FAIL oor_err_cnt got=%0d want=3", err_cnt); end
      total++; if (cmd_cnt !== 32'd8)  begin bad++; $display("FAIL err_cmd_cnt got=%0d want=8", cmd_cnt); end
   endtask

   task automatic test_full();
      bit ok;
      int unstable = 0;
      clear_logs();
      full = 1'b1;
      push_cmd(4'h1, 8'd5, 32'h0);
      push_cmd(4'h1, 8'd0, 32'h0);
      run(3);
      for (int i = 0; i < 20; i++) begin
         if (wr_en !== 1'b0 || din !== mk(4'h1, 8'd5, 32'hC0A8_0A03)) unstable++;
         tick();
      end
      total++; if (unstable != 0)         begin bad++; $display("FAIL full_hold bad_cycles got=%0d want=0", unstable); end
      total++; if (rsp_q.size() != 0)     begin bad++; $display("FAIL full_no_push got=%0d want=0", rsp_q.size()); end
      total++; if (rd_times.size() != 1)  begin bad++; $display("FAIL full_no_pop got=%0d want=1", rd_times.size()); end
      full = 1'b0;
      wait_rsp(2, 30, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL full_timeout got=%0d want=2", rsp_q.size()); end
      else begin
         total++; if (rsp_q[0] !== mk(4'h1, 8'd5, 32'hC0A8_0A03)) begin bad++; $display("FAIL full_rsp0 got=%h want=%h", rsp_q[0], mk(4'h1, 8'd5, 32'hC0A8_0A03)); end
         total++; if (rsp_q[1] !== mk(4'h1, 8'd0, 32'h6745_2301)) begin bad++; $display("FAIL full_rsp1 got=%h want=%h", rsp_q[1], mk(4'h1, 8'd0, 32'h6745_2301)); end
         total++; if (rd_times[1] - wr_times[0] != 1) begin bad++; $display("FAIL full_wr_to_rd got=%0d want=1", rd_times[1] - wr_times[0]); end
      end
      run(4);
      total++; if (rsp_q.size() != 2)  begin bad++; $display("FAIL full_single_push got=%0d want=2", rsp_q.size()); end
      total++; if (cmd_cnt !== 32'd10) begin bad++; $display("FAIL full_cmd_cnt got=%0d want=10", cmd_cnt); end
   endtask

   task automatic test_bad_opcode();
      bit ok;
      clear_logs();
      push_cmd(4'h7, 8'd2, 32'h0);
      push_cmd(4'h1, 8'd0, 32'h0);
      wait_rsp(1, 30, ok);
      run(6);
      total++;
      if (!ok) begin bad++; $display("FAIL badop_timeout got=%0d want=1", rsp_q.size()); end
      else if (rsp_q[0] !== mk(4'h1, 8'd0, 32'h6745_2301)) begin bad++; $display("FAIL badop_rsp got=%h want=%h", rsp_q[0], mk(4'h1, 8'd0, 32'h6745_2301)); end
      total++; if (rsp_q.size() != 1)  begin bad++; $display("FAIL badop_rsp_count got=%0d want=1", rsp_q.size()); end
      total++; if (err_cnt !== 16'd4)  begin bad++; $display("FAIL badop_err_cnt got=%0d want=4", err_cnt); end
      total++; if (cmd_cnt !== 32'd12) begin bad++; $display("FAIL badop_cmd_cnt got=%0d want=12", cmd_cnt); end
      total++;
      if (rd_times.size() != 2) begin bad++; $display("FAIL badop_pops got=%0d want=2", rd_times.size()); end
      else if (rd_times[1] - rd_times[0] != 2) begin bad++; $display("FAIL badop_rd_gap got=%0d want=2", rd_times[1] - rd_times[0]); end
   endtask

   task automatic test_reset_in_send();
      clear_logs();
      full = 1'b1;
      push_cmd(4'h1, 8'd5, 32'h0);
      run(4);
      total++; if (din !== mk(4'h1, 8'd5, 32'hC0A8_0A03)) begin bad++; $display("FAIL send_din got=%h want=%h", din, mk(4'h1, 8'd5, 32'hC0A8_0A03)); end
      rst = 1'b1;
      #1;
      total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL mrst_en got=%b%b want=00", rd_en, wr_en); end
      total++; if (din !== '0)             begin bad++; $display("FAIL mrst_din got=%h want=0", din); end
      total++; if (reg_at(5) !== 32'h0)    begin bad++; $display("FAIL mrst_reg5 got=%h want=0", reg_at(5)); end
      total++; if (reg_at(3) !== 32'h0)    begin bad++; $display("FAIL mrst_reg3 got=%h want=0", reg_at(3)); end
      total++; if (reg_at(0) !== 32'h0123_4567) begin bad++; $display("FAIL mrst_reg0 got=%h want=01234567", reg_at(0)); end
      total++; if (cmd_cnt !== 32'd0 || err_cnt !== 16'd0) begin bad++; $display("FAIL mrst_cnt got=%0d/%0d want=0/0", cmd_cnt, err_cnt); end
      run(2);
      rst  = 1'b0;
      full = 1'b0;
      run(10);
      total++; if (rsp_q.size() != 0)      begin bad++; $display("FAIL mrst_no_rsp got=%0d want=0", rsp_q.size()); end
      total++; if (rd_times.size() != 1)   begin bad++; $display("FAIL mrst_no_pop got=%0d want=1", rd_times.size()); end
   endtask

   initial begin
      rst   = 1'b1;
      full  = 1'b0;
      empty = 1'b1;
      dout  = '0;
      stb_last = '0;
      test_reset();
      test_read_reset();
      test_write();
      test_back_to_back();
      test_errors();
      test_full();
      test_bad_opcode();
      test_reset_in_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
